// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MUL/DIV take 32 iterations; MTHI/MTLO and divide-by-zero complete in one edge.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_mcand;
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic        r_neg_lo;
  logic        r_neg_hi;

  logic        w_sgn;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_sum;
  logic [63:0] w_prod_nx;
  logic [63:0] w_prod_fix;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [32:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  always_comb begin
    w_sgn   = ~op[0];
    w_a_mag = (w_sgn && A[31]) ? -A : A;
    w_b_mag = (w_sgn && B[31]) ? -B : B;
    // Shift-add: low half of r_prod holds the remaining multiplier bits.
    w_sum      = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_mcand : 32'd0)};
    w_prod_nx  = {w_sum, r_prod[31:1]};
    w_prod_fix = r_neg_lo ? -w_prod_nx : w_prod_nx;
    // Restoring divide: r_quo shifts the dividend out as quotient bits shift in.
    w_shift   = {r_rem[31:0], r_quo[31]};
    w_diff    = w_shift - {1'b0, r_dvsr};
    w_rem_nx  = w_diff[32] ? w_shift : w_diff;
    w_quo_nx  = {r_quo[30:0], ~w_diff[32]};
    w_quo_fix = r_neg_lo ? -w_quo_nx : w_quo_nx;
    w_rem_fix = r_neg_hi ? -w_rem_nx[31:0] : w_rem_nx[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_neg_lo    <= 1'b0;
      r_neg_hi    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                r_prod   <= {32'd0, w_b_mag};
                r_mcand  <= w_a_mag;
                r_neg_lo <= w_sgn & (A[31] ^ B[31]);
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= S_MUL;
              end
              3'b010, 3'b011: begin
                if (B == '0) begin
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  r_rem    <= '0;
                  r_quo    <= w_a_mag;
                  r_dvsr   <= w_b_mag;
                  r_neg_lo <= w_sgn & (A[31] ^ B[31]);
                  r_neg_hi <= w_sgn & A[31];
                  r_cnt    <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_DIV;
                end
              end
              3'b100:  HI <= A;
              3'b101:  LO <= A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_prod <= w_prod_nx;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            {HI, LO} <= w_prod_fix;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            LO      <= w_quo_fix;
            HI      <= w_rem_fix;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO results,
// a negedge monitor pops and compares whenever done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        scb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values; updates the HI/LO model.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output exp_t e, output logic push);
    longint      sa, sbv, q, r;
    logic [63:0] p, ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    push  = 1'b0;
    e.dbz = 1'b0;
    case (o)
      3'd0: begin p = sa * sbv; m_hi = p[63:32]; m_lo = p[31:0]; push = 1'b1; end
      3'd1: begin p = ua * ub;  m_hi = p[63:32]; m_lo = p[31:0]; push = 1'b1; end
      3'd2: begin
        push = 1'b1;
        if (b == 0) e.dbz = 1'b1;
        else begin q = sa / sbv; r = sa % sbv; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      3'd3: begin
        push = 1'b1;
        if (b == 0) e.dbz = 1'b1;
        else begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (scb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = scb.pop_front();
          chk("done_HI", HI, e.hi);
          chk("done_LO", LO, e.lo);
          chk("done_dbz", div_by_zero, e.dbz);
        end
      end else if (div_by_zero) begin
        chk("dbz_without_done", div_by_zero, 0);
      end
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Issues one op; returns at the negedge where the result is visible.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit now);
    exp_t e;
    logic push;
    int   n;
    model(o, a, b, e, push);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    if (push) scb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if ((o <= 3'd1) || ((o <= 3'd3) && b != 0)) begin
      wait_idle(n);
      chk("busy_cycles", n, 32);
      chk("done_at_end", done, 1);
    end else begin
      chk("busy_idle_op", busy, 0);
      if (o >= 3'd4) chk("no_done_idle_op", done, 0);
    end
    chk("HI_model", HI, m_hi);
    chk("LO_model", LO, m_lo);
  endtask

  initial begin
    int   n;
    int   seen;
    exp_t e;
    logic push;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_HI", HI, 0);
    chk("rst_LO", LO, 0);

    do_op(3'd0, 32'hFFFFFFFD, 32'd5, 0);
    chk("mult_HI", HI, 32'hFFFFFFFF);
    chk("mult_LO", LO, 32'hFFFFFFF1);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);   // back-to-back in done cycle
    chk("multu_HI", HI, 32'hFFFFFFFE);
    chk("multu_LO", LO, 32'h00000001);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_LO", LO, 32'hFFFFFFFD);
    chk("div_HI", HI, 32'hFFFFFFFF);
    do_op(3'd3, 32'd100, 32'd7, 0);
    chk("divu_LO", LO, 32'h0000000E);
    chk("divu_HI", HI, 32'h00000002);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("divovf_LO", LO, 32'h80000000);
    chk("divovf_HI", HI, 32'h0);

    do_op(3'd4, 32'd1, 32'd0, 0);
    do_op(3'd5, 32'd2, 32'd0, 1);
    do_op(3'd3, 32'd55, 32'd0, 0);
    chk("dbz_done", done, 1);
    chk("dbz_flag", div_by_zero, 1);
    chk("dbz_HI", HI, 32'd1);
    chk("dbz_LO", LO, 32'd2);

    do_op(3'd4, 32'h12345678, 32'd0, 0);
    chk("mthi_HI", HI, 32'h12345678);
    do_op(3'd5, 32'h9ABCDEF0, 32'd0, 1);
    chk("mtlo_LO", LO, 32'h9ABCDEF0);
    chk("mthi_HI_kept", HI, 32'h12345678);

    // Second start at busy cycle 5 must be ignored.
    model(3'd0, 32'd12345, 32'hFFFF0001, e, push);
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd12345; B = 32'hFFFF0001;
    scb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin start = 1'b1; op = 3'd1; A = 32'hDEADBEEF; B = 32'h777; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignored_busy_cycles", n, 32);
    chk("ignored_HI", HI, m_hi);
    chk("ignored_LO", LO, m_lo);
    repeat (3) @(negedge clk);
    chk("ignored_no_restart", busy, 0);

    // Reset at busy cycle 10 discards the operation.
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'hFFFFFFFF; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_HI", HI, 0);
    chk("midrst_LO", LO, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("no_done_after_rst", seen, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; op = 3'd4; A = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_HI", HI, 0);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", scb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
